// File: rtl/fir_filter_transposed_if.sv
// Sample stream, filtered output and coefficient-load signals of fir_filter_transposed.
// master drives samples and coefficients; slave is the filter side.
interface fir_filter_transposed_if #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32
);
  logic signed [DATA_W-1:0] incoming_signal_x;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [OUT_W-1:0]  output_signal_y;
  logic                     out_valid;
  logic                     coef_load;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_valid;
  logic                     coef_busy;
  logic                     sat_flag;

  modport master (
    output incoming_signal_x, in_valid, coef_load, coef_data, coef_valid,
    input  in_ready, output_signal_y, out_valid, coef_busy, sat_flag
  );

  modport slave (
    input  incoming_signal_x, in_valid, coef_load, coef_data, coef_valid,
    output in_ready, output_signal_y, out_valid, coef_busy, sat_flag
  );
endinterface

// File: rtl/fir_filter_transposed.sv
// Runtime-programmable transposed-form FIR with serial coefficient load and rounding.
// Define FIR_SATURATE_EN to clip the output (sticky sat_flag); otherwise it wraps.
module fir_filter_transposed #(
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 14
) (
  input logic clk,
  input logic reset,
  fir_filter_transposed_if.slave s_if
);
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W:0]   RND      = (ACC_W+1)'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) <<< FRAC_BITS;
`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W:0]   SAT_MAX  = ((ACC_W+1)'(1) <<< (OUT_W - 1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0]   SAT_MIN  = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [DATA_W-1:0] x_p0_q;
  logic                     vld_p0_q;
  logic signed [ACC_W-1:0]  prod [TAPS];
  logic signed [ACC_W-1:0]  z_p1_q [1:TAPS-1];
  logic signed [ACC_W-1:0]  yfull_p1_q;
  logic                     vld_p1_q;
  logic signed [OUT_W-1:0]  y_p2_q;
  logic                     vld_p2_q;
  logic                     ready, busy, accept, coef_wr, flush, load_start;

  // Round half toward +inf, keeping one guard bit so the offset cannot overflow.
  function automatic logic signed [ACC_W:0] round_fn(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W:0] t;
    t = {v[ACC_W-1], v} + RND;
    return t >>> FRAC_BITS;
  endfunction

`ifdef FIR_SATURATE_EN
  function automatic logic ovf_fn(input logic signed [ACC_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] reduce_fn(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] reduce_fn(input logic signed [ACC_W:0] v);
    return v[OUT_W-1:0];
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (s_if.coef_load) begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
      S_LOAD: if (s_if.coef_valid) begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    coef_wr    = (state_q == S_LOAD) && s_if.coef_valid;
    flush      = (state_q == S_FLUSH);
    load_start = (state_q == S_IDLE) && s_if.coef_load;
  end

  assign accept = s_if.in_valid & ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_q[k] <= (k == 0) ? COEF_ONE : '0;
    end else if (coef_wr) begin
      coef_q[idx_q] <= s_if.coef_data;
    end
  end

  // Stage p0: capture accepted sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_p0_q   <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      vld_p0_q <= accept;
      if (accept)     x_p0_q <= s_if.incoming_signal_x;
      else if (flush) x_p0_q <= '0;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) prod[k] = ACC_W'(x_p0_q) * ACC_W'(coef_q[k]);
  end

  // Stage p1: transposed delay line and full-precision output sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k < TAPS; k++) z_p1_q[k] <= '0;
      yfull_p1_q <= '0;
      vld_p1_q   <= 1'b0;
    end else begin
      vld_p1_q <= vld_p0_q;
      if (flush) begin
        for (int k = 1; k < TAPS; k++) z_p1_q[k] <= '0;
      end else if (vld_p0_q) begin
        for (int k = 1; k <= TAPS - 2; k++) z_p1_q[k] <= prod[k] + z_p1_q[k+1];
        z_p1_q[TAPS-1] <= prod[TAPS-1];
      end
      if (vld_p0_q) yfull_p1_q <= prod[0] + z_p1_q[1];
    end
  end

  // Stage p2: quantised, width-reduced output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_p2_q   <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) y_p2_q <= reduce_fn(round_fn(yfull_p1_q));
    end
  end

`ifdef FIR_SATURATE_EN
  logic sat_q;

  // A clip landing in the same cycle as a load request wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         sat_q <= 1'b0;
    else if (vld_p1_q && ovf_fn(round_fn(yfull_p1_q))) sat_q <= 1'b1;
    else if (load_start)                               sat_q <= 1'b0;
  end

  assign s_if.sat_flag = sat_q;
`else
  assign s_if.sat_flag = 1'b0;
`endif

  assign s_if.in_ready        = ready;
  assign s_if.coef_busy       = busy;
  assign s_if.output_signal_y = y_p2_q;
  assign s_if.out_valid       = vld_p2_q;
endmodule
